// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and control-bundle layout for alu_seq
package alu_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit positions of the decoder's packed 7-bit control bundle
    localparam int CTL_ZX  = 0;
    localparam int CTL_NX  = 1;
    localparam int CTL_ZY  = 2;
    localparam int CTL_NY  = 3;
    localparam int CTL_F   = 4;
    localparam int CTL_NO  = 5;
    localparam int CTL_MUL = 6;
    localparam int CTL_W   = 7;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational Hack ALU slice: operand preprocessing, add/and, negate, carry/overflow
module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] r_final,
    output logic             cy,
    output logic             ov
);

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    assign x1  = zx ? '0 : x;
    assign x2  = nx ? ~x1 : x1;
    assign y1  = zy ? '0 : y;
    assign y2  = ny ? ~y1 : y1;
    assign sum = {1'b0, x2} + {1'b0, y2};
    assign r   = f ? sum[WIDTH-1:0] : (x2 & y2);

    // Flags describe the adder before the final inversion
    assign cy      = f & sum[WIDTH];
    assign ov      = f & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
    assign r_final = no ? ~r : r;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered Hack ALU with carry/overflow, valid/ready handshake and iterative multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);

    localparam int CW = $clog2(WIDTH);

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               no_q;

    logic [CTL_W-1:0]   ctl;
    logic [WIDTH-1:0]   core_x2, core_y2, core_r;
    logic               core_cy, core_ov;
    logic               accept, mul_op;
    logic [2*WIDTH-1:0] partial;

    logic               load;
    logic [WIDTH-1:0]   ld_out;
    logic               ld_cy, ld_ov;

    assign ctl = {mul, no, f, ny, zy, nx, zx};

    alu_core #(.WIDTH(WIDTH)) u_core (
        .x       (x),
        .y       (y),
        .zx      (ctl[CTL_ZX]),
        .nx      (ctl[CTL_NX]),
        .zy      (ctl[CTL_ZY]),
        .ny      (ctl[CTL_NY]),
        .f       (ctl[CTL_F]),
        .no      (ctl[CTL_NO]),
        .x2      (core_x2),
        .y2      (core_y2),
        .r_final (core_r),
        .cy      (core_cy),
        .ov      (core_ov)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_op   = ctl[CTL_MUL] && (MUL_EN != 0);
    assign partial  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        ld_out  = '0;
        ld_cy   = 1'b0;
        ld_ov   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (mul_op) begin
                        state_n = ST_MUL;
                    end else begin
                        load   = 1'b1;
                        ld_out = core_r;
                        ld_cy  = core_cy;
                        ld_ov  = core_ov;
                    end
                end
            end
            ST_MUL: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = ST_IDLE;
                    load    = 1'b1;
                    ld_out  = no_q ? ~partial[WIDTH-1:0] : partial[WIDTH-1:0];
                    ld_ov   = |partial[2*WIDTH-1:WIDTH];
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            no_q      <= 1'b0;
            out       <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
            cy        <= 1'b0;
            ov        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && accept && mul_op) begin
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, core_x2};
                mplier <= core_y2;
                no_q   <= ctl[CTL_NO];
            end else if (state == ST_MUL) begin
                // Shift-add: one multiplier bit consumed per cycle, LSB first
                acc    <= partial;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (load) begin
                out       <= ld_out;
                zr        <= (ld_out == '0);
                ng        <= ld_out[WIDTH-1];
                cy        <= ld_cy;
                ov        <= ld_ov;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
